router_sync_n: RTL and testbench
================================

Name: router_sync_n

Overview:
- Parametrised write-side synchroniser for the router; sits between the router FSM/register block and NUM_CH output FIFOs.
- Latches the packet destination on detect_addr and steers the single write enable to the selected FIFO.
- Muxes back that FIFO's full flag and drives per-channel valid outputs.
- Runs a per-channel read-inactivity timer that pulses a soft reset to stalled FIFOs. It also flags out-of-range destination addresses.

Parameters:
- NUM_CH, 3: number of output channels/FIFOs (2..8).
- ADDR_W, 2: destination address width; must be at least clog2(NUM_CH), otherwise an elaboration error.
- TIMEOUT, 30: consecutive stalled cycles before soft reset; must be at least 2.
- CNT_W, clog2(TIMEOUT): timer width. Derived; not for override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- din  in  ADDR_W  destination address from header byte
- detect_addr  in  1  header-valid strobe; capture din
- wr_en_reg  in  1  write request from router FSM
- full  in  NUM_CH  per-FIFO full flags
- empty  in  NUM_CH  per-FIFO empty flags
- rd_en  in  NUM_CH  per-FIFO read enables from the downstream reader
- wr_en  out  NUM_CH  one-hot (or zero) FIFO write enables
- fifo_full  out  1  full flag of the selected FIFO
- vld_out  out  NUM_CH  per-channel data available
- soft_reset  out  NUM_CH  per-channel single-cycle timeout reset pulse
- addr_err  out  1  single-cycle pulse; captured address is out of range

Behaviour:
- Reset is synchronous: rst low at a rising edge.
  - Values after reset: sel=0, sel_vld=0, addr_err=0, all timers=0, soft_reset=0.
  - Consequences: wr_en=0, fifo_full=0.
- Address capture, on each edge with detect_addr=1:
  - sel is loaded with din.
  - sel_vld is set to (din < NUM_CH).
  - addr_err is set to (din >= NUM_CH).
- addr_err is otherwise 0. It is high for exactly one cycle per bad capture.
- Back-to-back detect_addr: each capture overwrites the previous one. There is no queueing.
- wr_en is combinational from registered state: wr_en[i] = wr_en_reg & sel_vld & (sel==i).
  - In the cycle where detect_addr is high, wr_en reflects the previous selection. The new selection takes effect the next cycle (1-cycle latency).
- fifo_full is combinational: full[sel] if sel_vld, else 0.
  - An invalid or unset destination therefore never stalls the FSM and never writes.
- vld_out[i] = ~empty[i], combinational, with no reset dependency.
- Per-channel timer i, evaluated each edge (rst high):
  - empty[i]=1 or rd_en[i]=1: timer to 0, soft_reset[i] to 0.
  - Otherwise, if timer==TIMEOUT-1: timer to 0, soft_reset[i] to 1.
  - Otherwise: timer+1, soft_reset[i] to 0.
- soft_reset[i] is high for exactly one cycle, following the TIMEOUT-th consecutive edge with empty[i]=0 and rd_en[i]=0.
  - If the FIFO is still non-empty afterwards, the timer restarts and a further pulse follows TIMEOUT cycles later.
- A single rd_en[i] cycle anywhere in the window restarts the count from 0. The timer never saturates or wraps past TIMEOUT-1.
- Channels are fully independent. Simultaneous soft_reset pulses on several channels are legal.
- soft_reset does not alter sel or sel_vld. Writes to a channel being soft-reset are not blocked here; that is the FSM's responsibility.
- Reset mid-count: all timers clear and any pending pulse is cancelled in the same cycle. A post-reset sel_vld=0 blocks writes until the next detect_addr.

Decomposition:
- Shared package router_pkg:
  - ROUTER_NUM_CH, ROUTER_ADDR_W and ROUTER_TIMEOUT defaults.
  - A clog2-style width helper.
- One sub-module router_sync_timer, instantiated NUM_CH times in a generate loop.
  - Parameter: TIMEOUT.
  - Ports: clk, rst, vld, rd_en, soft_reset.
- Address capture and write steering stay in router_sync_n.

Test Plan:
1. Reset, then wr_en_reg=1 with no detect_addr -> wr_en=000, fifo_full=0 even with full=111.
2. din=2 with detect_addr for 1 cycle, then wr_en_reg=1 and full=100 -> wr_en=000 in the capture cycle, 100 from the next cycle; fifo_full=1. Then din=1 captured, full=000 -> wr_en=010, fifo_full=0.
3. din=3 with detect_addr (NUM_CH=3) -> addr_err=1 for exactly one cycle; wr_en=000 and fifo_full=0 until a valid address is captured.
4. empty[0]=0, rd_en[0]=0 held 30 cycles -> soft_reset[0] high exactly one cycle after the 30th edge, low otherwise. Held 60 cycles -> two pulses, 30 cycles apart.
5. empty[1]=0 for 29 idle cycles, then rd_en[1]=1 for one cycle, then idle -> no pulse at cycle 30; pulse after 30 further idle cycles. Repeat with empty[1] going to 1 at cycle 29 -> no pulse.
6. Channel 2 stalled for 20 cycles, rst low for 1 cycle, then stalled again -> soft_reset[2] first pulses 30 cycles after reset release, and sel_vld is cleared (wr_en=000).

Source files
------------

// File: rtl/router_pkg.sv
// Router shared definitions: default sizing and a width helper
// used by the write-side synchroniser and its timers.
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_ADDR_W  = 2;
  localparam int ROUTER_TIMEOUT = 30;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2w(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/router_sync_n_if.sv
// Write-side bus between router FSM/FIFOs and the synchroniser.
// slave is the synchroniser side, master the surrounding logic.
interface router_sync_n_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);

  logic [ADDR_W-1:0] din;
  logic              detect_addr;
  logic              wr_en_reg;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] rd_en;
  logic [NUM_CH-1:0] wr_en;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  modport slave (
    input  din, detect_addr, wr_en_reg,
    input  full, empty, rd_en,
    output wr_en, fifo_full, vld_out,
    output soft_reset, addr_err
  );

  modport master (
    output din, detect_addr, wr_en_reg,
    output full, empty, rd_en,
    input  wr_en, fifo_full, vld_out,
    input  soft_reset, addr_err
  );

endinterface

// File: rtl/router_sync_timer.sv
// Per-channel read-inactivity timer: one-cycle soft_reset
// after TIMEOUT consecutive cycles with data and no read.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd_en,
  output logic soft_reset
);

  localparam int CNT_W = clog2w(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("router_sync_timer: TIMEOUT must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sr_q, sr_d;

  always_comb begin
    cnt_d = '0;
    sr_d  = 1'b0;
    if (vld && !rd_en) begin
      if (cnt_q == LAST) sr_d = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      sr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign soft_reset = sr_q;

endmodule

// File: rtl/router_sync_n.sv
// Router write-side synchroniser: latches destination, steers
// the write enable, muxes full, and times out stalled FIFOs.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int ADDR_W  = ROUTER_ADDR_W,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  router_sync_n_if.slave bus
);

  if (ADDR_W < clog2w(NUM_CH)) begin : g_bad_addr_w
    $error("router_sync_n: ADDR_W too narrow for NUM_CH");
  end

  localparam logic [ADDR_W:0] NCH = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] sel_q, sel_d;
  logic              sel_vld_q, sel_vld_d;
  logic              err_q, err_d;
  logic              din_ok;
  logic [NUM_CH-1:0] sel_oh;

  assign din_ok = ({1'b0, bus.din} < NCH);

  always_comb begin
    sel_d     = sel_q;
    sel_vld_d = sel_vld_q;
    err_d     = 1'b0;
    if (bus.detect_addr) begin
      sel_d     = bus.din;
      sel_vld_d = din_ok;
      err_d     = !din_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      sel_vld_q <= sel_vld_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel_oh[i] = sel_vld_q && (sel_q == ADDR_W'(i));

    router_sync_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .vld       (~bus.empty[i]),
      .rd_en     (bus.rd_en[i]),
      .soft_reset(bus.soft_reset[i])
    );
  end

  // Invalid or unset destination neither writes nor stalls.
  assign bus.wr_en     = sel_oh & {NUM_CH{bus.wr_en_reg}};
  assign bus.fifo_full = |(sel_oh & bus.full);
  assign bus.vld_out   = ~bus.empty;
  assign bus.addr_err  = err_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Directed scoreboard bench for router_sync_n (3 channels,
// 2-bit address, TIMEOUT 30).
module tb_router_sync_n;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

  router_sync_n #(
    .NUM_CH (3),
    .ADDR_W (2),
    .TIMEOUT(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  string      tag_q[$];
  logic [7:0] exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic push(input string tag, input logic [7:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    string      t;
    logic [7:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  function automatic logic [7:0] w3(input logic [2:0] v);
    return {5'b0, v};
  endfunction

  initial begin
    bus.din         = '0;
    bus.detect_addr = 1'b0;
    bus.wr_en_reg   = 1'b0;
    bus.full        = '0;
    bus.empty       = 3'b111;
    bus.rd_en       = '0;

    // reset
    step();
    step();
    rst = 1'b1;
    push("rst_wr_en", 8'h0);
    push("rst_full", 8'h0);
    push("rst_sr", 8'h0);
    push("rst_err", 8'h0);
    obs();
    pop_check(w3(bus.wr_en));
    pop_check({7'b0, bus.fifo_full});
    pop_check(w3(bus.soft_reset));
    pop_check({7'b0, bus.addr_err});

    // 1: write request without a destination
    bus.wr_en_reg = 1'b1;
    bus.full      = 3'b111;
    push("t1_wr_en", 8'h0);
    push("t1_full", 8'h0);
    obs();
    pop_check(w3(bus.wr_en));
    pop_check({7'b0, bus.fifo_full});

    // 2: capture din=2, then din=1
    step();
    bus.din         = 2'd2;
    bus.detect_addr = 1'b1;
    bus.full        = 3'b100;
    push("t2_cap_wr_en", 8'h0);
    obs();
    pop_check(w3(bus.wr_en));
    step();
    bus.detect_addr = 1'b0;
    push("t2_wr_en2", 8'h4);
    push("t2_full2", 8'h1);
    obs();
    pop_check(w3(bus.wr_en));
    pop_check({7'b0, bus.fifo_full});
    bus.din         = 2'd1;
    bus.detect_addr = 1'b1;
    bus.full        = 3'b000;
    step();
    bus.detect_addr = 1'b0;
    push("t2_wr_en1", 8'h2);
    push("t2_full1", 8'h0);
    obs();
    pop_check(w3(bus.wr_en));
    pop_check({7'b0, bus.fifo_full});

    // 3: out-of-range address
    bus.din         = 2'd3;
    bus.detect_addr = 1'b1;
    bus.full        = 3'b111;
    step();
    bus.detect_addr = 1'b0;
    push("t3_err", 8'h1);
    push("t3_wr_en", 8'h0);
    push("t3_full", 8'h0);
    obs();
    pop_check({7'b0, bus.addr_err});
    pop_check(w3(bus.wr_en));
    pop_check({7'b0, bus.fifo_full});
    step();
    push("t3_err_drop", 8'h0);
    push("t3_wr_en_hold", 8'h0);
    obs();
    pop_check({7'b0, bus.addr_err});
    pop_check(w3(bus.wr_en));
    bus.din         = 2'd0;
    bus.detect_addr = 1'b1;
    step();
    bus.detect_addr = 1'b0;
    push("t3_recover_wr_en", 8'h1);
    push("t3_recover_full", 8'h1);
    obs();
    pop_check(w3(bus.wr_en));
    pop_check({7'b0, bus.fifo_full});

    // 4: channel 0 stalled for 60 edges
    bus.wr_en_reg = 1'b0;
    bus.full      = '0;
    step();
    bus.empty = 3'b110;
    push("t4_vld_out", 8'h1);
    obs();
    pop_check(w3(bus.vld_out));
    for (int k = 1; k <= 60; k++) begin
      push($sformatf("t4_sr_k%0d", k),
           (k == 30 || k == 60) ? 8'h1 : 8'h0);
      step();
      obs();
      pop_check(w3(bus.soft_reset));
    end
    bus.empty = 3'b111;
    step();

    // 5a: channel 1, single read at edge 30
    bus.empty = 3'b101;
    for (int k = 1; k <= 60; k++) begin
      bus.rd_en = (k == 30) ? 3'b010 : 3'b000;
      push($sformatf("t5a_sr_k%0d", k),
           (k == 60) ? 8'h2 : 8'h0);
      step();
      obs();
      pop_check(w3(bus.soft_reset));
    end
    bus.rd_en = '0;
    bus.empty = 3'b111;
    step();

    // 5b: channel 1 drains at edge 30
    bus.empty = 3'b101;
    for (int k = 1; k <= 35; k++) begin
      bus.empty = (k >= 30) ? 3'b111 : 3'b101;
      push($sformatf("t5b_sr_k%0d", k), 8'h0);
      step();
      obs();
      pop_check(w3(bus.soft_reset));
    end

    // 6: reset mid-count on channel 2
    bus.din         = 2'd2;
    bus.detect_addr = 1'b1;
    bus.wr_en_reg   = 1'b1;
    step();
    bus.detect_addr = 1'b0;
    bus.empty       = 3'b011;
    push("t6_wr_en_pre", 8'h4);
    obs();
    pop_check(w3(bus.wr_en));
    for (int k = 1; k <= 20; k++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    push("t6_rst_wr_en", 8'h0);
    push("t6_rst_sr", 8'h0);
    obs();
    pop_check(w3(bus.wr_en));
    pop_check(w3(bus.soft_reset));
    for (int k = 1; k <= 30; k++) begin
      push($sformatf("t6_sr_k%0d", k),
           (k == 30) ? 8'h4 : 8'h0);
      step();
      obs();
      pop_check(w3(bus.soft_reset));
    end
    push("t6_wr_en_post", 8'h0);
    obs();
    pop_check(w3(bus.wr_en));

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_left observed=%0d expected=0",
             exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
